// File: rtl/cdb_arbiter.sv
// Two-bus common-data-bus arbiter: grants up to two pending results per cycle and registers them onto cdb[0]/cdb[1].
// Define CDB_FIXED_PRIORITY_EN for fixed priority (index 0 highest, no rotating pointer).
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32,
    parameter int REG_W   = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*XLEN-1:0]  req_data,
    input  logic [NUM_REQ*REG_W-1:0] req_arn,
    input  logic [NUM_REQ*REG_W-1:0] req_rrn,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [1:0]               cdb_valid,
    output logic [2*XLEN-1:0]        cdb_data,
    output logic [2*REG_W-1:0]       cdb_arn,
    output logic [2*REG_W-1:0]       cdb_rrn
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                 active;
    logic [PTR_W-1:0]     scan_base;
    logic [PTR_W-1:0]     scan_idx;
    int                   scan_pos;
    logic                 g0_found, g1_found;
    logic [PTR_W-1:0]     g0_idx, g1_idx;
    logic [NUM_REQ-1:0]   gnt0, gnt1;
    logic [XLEN-1:0]      data0_nxt, data1_nxt;
    logic [REG_W-1:0]     arn0_nxt, arn1_nxt, rrn0_nxt, rrn1_nxt;

    // Reset and flush both suppress every grant in the cycle they are asserted.
    assign active = reset_n & ~flush;

`ifdef CDB_FIXED_PRIORITY_EN
    assign scan_base = '0;
`else
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W-1:0] rr_ptr_nxt;

    assign scan_base = rr_ptr;
    assign last_idx  = g1_found ? g1_idx : g0_idx;

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (g0_found) begin
            if (last_idx == PTR_W'(NUM_REQ - 1))
                rr_ptr_nxt = '0;
            else
                rr_ptr_nxt = last_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush)
            rr_ptr <= '0;
        else
            rr_ptr <= rr_ptr_nxt;
    end
`endif

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        g0_found = 1'b0;
        g1_found = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        gnt0     = '0;
        gnt1     = '0;
        scan_pos = 0;
        scan_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_pos = int'(scan_base) + off;
            if (scan_pos >= NUM_REQ)
                scan_pos = scan_pos - NUM_REQ;
            scan_idx = PTR_W'(scan_pos);
            if (active && req_valid[scan_idx]) begin
                if (!g0_found) begin
                    g0_found       = 1'b1;
                    g0_idx         = scan_idx;
                    gnt0[scan_idx] = 1'b1;
                end else if (!g1_found) begin
                    g1_found       = 1'b1;
                    g1_idx         = scan_idx;
                    gnt1[scan_idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready = gnt0 | gnt1;

    // One-hot AND-OR payload select; an unused slot collapses to all-zero fields.
    always_comb begin
        data0_nxt = '0;
        data1_nxt = '0;
        arn0_nxt  = '0;
        arn1_nxt  = '0;
        rrn0_nxt  = '0;
        rrn1_nxt  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            data0_nxt = data0_nxt | ({XLEN{gnt0[i]}}  & req_data[i*XLEN +: XLEN]);
            data1_nxt = data1_nxt | ({XLEN{gnt1[i]}}  & req_data[i*XLEN +: XLEN]);
            arn0_nxt  = arn0_nxt  | ({REG_W{gnt0[i]}} & req_arn[i*REG_W +: REG_W]);
            arn1_nxt  = arn1_nxt  | ({REG_W{gnt1[i]}} & req_arn[i*REG_W +: REG_W]);
            rrn0_nxt  = rrn0_nxt  | ({REG_W{gnt0[i]}} & req_rrn[i*REG_W +: REG_W]);
            rrn1_nxt  = rrn1_nxt  | ({REG_W{gnt1[i]}} & req_rrn[i*REG_W +: REG_W]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            cdb_valid <= '0;
            cdb_data  <= '0;
            cdb_arn   <= '0;
            cdb_rrn   <= '0;
        end else begin
            cdb_valid <= {g1_found, g0_found};
            cdb_data  <= {data1_nxt, data0_nxt};
            cdb_arn   <= {arn1_nxt, arn0_nxt};
            cdb_rrn   <= {rrn1_nxt, rrn0_nxt};
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table plus randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int N     = 4;
    localparam int XLEN  = 32;
    localparam int REG_W = 6;
    localparam int BW    = XLEN + 2 * REG_W;

    logic               clk = 1'b0;
    logic               reset_n, flush;
    logic [N-1:0]       req_valid, req_ready;
    logic [N*XLEN-1:0]  req_data;
    logic [N*REG_W-1:0] req_arn, req_rrn;
    logic [1:0]         cdb_valid;
    logic [2*XLEN-1:0]  cdb_data;
    logic [2*REG_W-1:0] cdb_arn, cdb_rrn;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .REG_W(REG_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_data(req_data), .req_arn(req_arn), .req_rrn(req_rrn),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
        .cdb_arn(cdb_arn), .cdb_rrn(cdb_rrn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester payload held by the bench.
    logic [XLEN-1:0]  p_data [N];
    logic [REG_W-1:0] p_arn  [N];
    logic [REG_W-1:0] p_rrn  [N];

    task automatic pack_payload();
        for (int i = 0; i < N; i++) begin
            req_data[i*XLEN +: XLEN]   = p_data[i];
            req_arn[i*REG_W +: REG_W]  = p_arn[i];
            req_rrn[i*REG_W +: REG_W]  = p_rrn[i];
        end
    endtask

    function automatic logic [BW-1:0] bus_word(input int idx);
        if (idx < 0) return '0;
        return {p_data[idx], p_arn[idx], p_rrn[idx]};
    endfunction

    function automatic logic [BW-1:0] dut_bus(input int k);
        return {cdb_data[k*XLEN +: XLEN], cdb_arn[k*REG_W +: REG_W], cdb_rrn[k*REG_W +: REG_W]};
    endfunction

    typedef struct {
        logic         rst_n;
        logic         fl;
        logic [N-1:0] valid;
        logic [N-1:0] exp_ready;
        logic [1:0]   exp_cdb_valid;
        int           exp_b0;   // requester index on cdb[0], -1 = idle
        int           exp_b1;
        int           exp_ptr;
    } vec_t;

    vec_t vecs[$];

    task automatic run_table();
        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            reset_n   = vecs[r].rst_n;
            flush     = vecs[r].fl;
            req_valid = vecs[r].valid;
            #1;
            check($sformatf("row%0d ready", r), 64'(req_ready), 64'(vecs[r].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("row%0d cdb_valid", r), 64'(cdb_valid), 64'(vecs[r].exp_cdb_valid));
            check($sformatf("row%0d bus0", r), 64'(dut_bus(0)), 64'(bus_word(vecs[r].exp_b0)));
            check($sformatf("row%0d bus1", r), 64'(dut_bus(1)), 64'(bus_word(vecs[r].exp_b1)));
`ifndef CDB_FIXED_PRIORITY_EN
            check($sformatf("row%0d rr_ptr", r), 64'(dut.rr_ptr), 64'(vecs[r].exp_ptr));
`endif
        end
    endtask

    // Reference model: order requesters by distance from the pointer and take the first two valid ones.
    int m_ptr;

    function automatic void model_grants(input logic [N-1:0] v, input int ptr, output int g[$]);
        g = {};
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i] && g.size() < 2) g.push_back(i);
        end
    endfunction

    task automatic run_random(input int cycles);
        logic [N-1:0] held = '0;
        int           wait_cnt[N];
        int           g[$];
        logic         r_rst, r_fl;
        logic [N-1:0] exp_ready;
        logic [BW-1:0] exp0, exp1;
        logic [1:0]   exp_v;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        m_ptr = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            r_rst = ($urandom_range(0, 39) != 0);
            r_fl  = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                if (!held[i] && $urandom_range(0, 1) == 1) begin
                    held[i]   = 1'b1;
                    p_data[i] = $urandom;
                    p_arn[i]  = REG_W'($urandom);
                    p_rrn[i]  = REG_W'($urandom);
                end
            end
            reset_n   = r_rst;
            flush     = r_fl;
            req_valid = held;
            pack_payload();
`ifdef CDB_FIXED_PRIORITY_EN
            model_grants(held, 0, g);
`else
            model_grants(held, m_ptr, g);
`endif
            if (!r_rst || r_fl) g = {};
            exp_ready = '0;
            foreach (g[j]) exp_ready[g[j]] = 1'b1;
            exp_v = 2'(g.size() >= 1) | (2'(g.size() == 2) << 1);
            exp0  = bus_word(g.size() >= 1 ? g[0] : -1);
            exp1  = bus_word(g.size() == 2 ? g[1] : -1);
            #1;
            check("rand ready", 64'(req_ready), 64'(exp_ready));
            @(posedge clk);
            #1;
            check("rand cdb_valid", 64'(cdb_valid), 64'(exp_v));
            check("rand bus0", 64'(dut_bus(0)), 64'(exp0));
            check("rand bus1", 64'(dut_bus(1)), 64'(exp1));
            if (!r_rst || r_fl) begin
                m_ptr = 0;
                held  = '0;
                for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            end else begin
                if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % N;
                for (int i = 0; i < N; i++) if (held[i]) wait_cnt[i]++;
                foreach (g[j]) begin
`ifndef CDB_FIXED_PRIORITY_EN
                    check("fairness", 64'(wait_cnt[g[j]] <= ((N - 1) + 1) / 2 + 1), 64'(1));
`endif
                    wait_cnt[g[j]] = 0;
                    held[g[j]]     = 1'b0;
                end
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        p_data = '{32'h11, 32'h12, 32'h22, 32'h44};
        p_arn  = '{6'd5, 6'd6, 6'd7, 6'd8};
        p_rrn  = '{6'd30, 6'd31, 6'd40, 6'd42};
        pack_payload();

`ifndef CDB_FIXED_PRIORITY_EN
        //           rst  fl    valid    ready    cdbv   b0  b1 ptr
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, -1, -1, 0});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000, 2'b00, -1, -1, 0});
        vecs.push_back('{1'b1, 1'b0, 4'b0101, 4'b0101, 2'b11,  0,  2, 3});
        vecs.push_back('{1'b1, 1'b0, 4'b1000, 4'b1000, 2'b01,  3, -1, 0});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0011, 2'b11,  0,  1, 2});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b1100, 2'b11,  2,  3, 0});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0011, 2'b11,  0,  1, 2});
        vecs.push_back('{1'b1, 1'b1, 4'b0011, 4'b0000, 2'b00, -1, -1, 0});
        vecs.push_back('{1'b1, 1'b0, 4'b0110, 4'b0110, 2'b11,  1,  2, 3});
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, -1, -1, 3});
        vecs.push_back('{1'b1, 1'b0, 4'b0010, 4'b0010, 2'b01,  1, -1, 2});
        vecs.push_back('{1'b1, 1'b0, 4'b0101, 4'b0101, 2'b11,  2,  0, 1});
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 2'b00, -1, -1, 0});
`else
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, -1, -1, 0});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0011, 2'b11,  0,  1, 0});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0011, 2'b11,  0,  1, 0});
        vecs.push_back('{1'b1, 1'b0, 4'b1100, 4'b1100, 2'b11,  2,  3, 0});
        vecs.push_back('{1'b1, 1'b1, 4'b0011, 4'b0000, 2'b00, -1, -1, 0});
`endif
        run_table();

        // Flush directly after a cycle with both buses valid.
        @(negedge clk);
        reset_n = 1'b1; flush = 1'b0; req_valid = 4'b1010;
        @(posedge clk); #1;
        check("pre-flush cdb_valid", 64'(cdb_valid), 64'(2'b11));
        @(negedge clk);
        flush = 1'b1; req_valid = 4'b0011;
        #1;
        check("flush ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        check("flush cdb_valid", 64'(cdb_valid), 64'(0));
        check("flush cdb_data", 64'(cdb_data), 64'(0));
        @(negedge clk);
        flush = 1'b0; req_valid = '0;

        run_random(2000);

        @(negedge clk);
        req_valid = '0;
        flush     = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the two common data buses (cdb[0], cdb[1]) among NUM_REQ execution-unit result ports.
- Each cycle it grants at most two pending results using a round-robin pointer, then registers them onto the buses.
- Its outputs feed the operand-bypass comparators, the reservation stations and the ROB.
- An idle bus drives all-zero fields, so consumers never see a stale tag match.

Parameters:
- NUM_REQ, 4, number of requesting result ports (2..8).
- XLEN, 32, data width.
- REG_W, 6, width of arn and rrn tags.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- flush  in  1  pipeline flush (branch mispredict), synchronous.
- req_valid  in  NUM_REQ  result pending, one bit per requester.
- req_data  in  NUM_REQ*XLEN  result data, flattened; requester i occupies slice [i*XLEN +: XLEN].
- req_arn  in  NUM_REQ*REG_W  architectural destination tag, flattened.
- req_rrn  in  NUM_REQ*REG_W  rename destination tag, flattened.
- req_ready  out  NUM_REQ  grant; transfer occurs when req_valid[i] & req_ready[i].
- cdb_valid  out  2  bus k carries a result.
- cdb_data  out  2*XLEN  bus data, flattened.
- cdb_arn  out  2*REG_W  bus architectural tag, flattened.
- cdb_rrn  out  2*REG_W  bus rename tag, flattened.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, reset_n.
- Reset (reset_n=0 at a clk edge): cdb_valid=0, cdb_data/arn/rrn=0, rr_ptr=0. req_ready=0 while reset_n=0.
- Handshake:
  - A requester holds valid and its payload stable until it sees ready.
  - req_ready is combinational from the current req_valid and rr_ptr.
  - req_ready[i] is never 1 when req_valid[i]=0.
- Grant selection, scanning indices rr_ptr, rr_ptr+1, ... mod NUM_REQ:
  - First valid index found -> slot 0 (cdb[0]).
  - Second valid index found -> slot 1 (cdb[1]).
  - At most 2 grants per cycle; remaining requesters wait.
- Latency: a granted payload appears on its bus at the next clk edge and stays for exactly one cycle unless re-granted.
- Bus idle: a bus with no grant has cdb_valid[k]=0 and data/arn/rrn=0 in the following cycle.
- Single grant: if only one grant exists it always uses cdb[0]; cdb[1] goes idle.
- Pointer update:
  - Any grant: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - No grant: rr_ptr unchanged.
  - Wrap-around: last grant at NUM_REQ-1 -> rr_ptr=0.
- Fairness bound: a continuously valid requester is granted within ceil((NUM_REQ-1)/2)+1 cycles.
- Flush: when flush=1 in a cycle:
  - req_ready=0 in that cycle; no transfer occurs.
  - At the next edge: cdb_valid=0, all bus fields=0, rr_ptr=0.
  - Requesters drop their own valids; the arbiter does not track them.
- Precedence: reset has priority over flush.
- Reset or flush mid-operation discards in-flight bus contents without any partial output.
- No combinational path from cdb outputs to req_ready.

Optional Feature:
- Macro: CDB_FIXED_PRIORITY_EN.
- Defined: grant order is fixed, index 0 highest priority. The scan always starts at 0 and rr_ptr is removed, so there is no fairness bound.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, all req_valid=0 -> cdb_valid=2'b00, all bus fields 0, req_ready=0.
- Two requesters: req_valid=4'b0101, data[0]=0x11, arn[0]=5, data[2]=0x22, rrn[2]=40, rr_ptr=0 -> req_ready=4'b0101.
  - Next cycle: cdb[0]={0x11, arn 5}, cdb[1]={0x22, rrn 40}.
  - rr_ptr=3.
- Round-robin and wrap: all 4 valid and held for 3 cycles, rr_ptr=0 -> grants {0,1}, then {2,3}, then {0,1}; rr_ptr goes 2, 0, 2.
- Single requester: req_valid=4'b1000 -> it goes out on cdb[0] next cycle; cdb[1] idle (valid 0, data 0); rr_ptr=0 (wrap).
- Flush: req_valid=4'b0011 with flush=1 -> req_ready=0; next cycle cdb_valid=0 and rr_ptr=0, even though the previous cycle's buses were valid.
- Fixed priority (with CDB_FIXED_PRIORITY_EN): all 4 valid and held for 2 cycles -> grants {0,1} in both cycles; requesters 2 and 3 are never granted.
